// File: rtl/clamp_seq_pkg.sv
// rtl/clamp_seq_pkg.sv - shared types and elaboration helpers for clamp_seq
// Purpose: FSM state encoding, index-width helper and parameter sanity check
//          shared by the clamp_seq interface, top and clamp stage.
// Ports:   none (package).
package clamp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Width of the component index; a single-component vector still needs one bit.
  function automatic int idx_width(input int ncomp);
    return (ncomp > 1) ? $clog2(ncomp) : 1;
  endfunction

  // The clamp needs a sign bit plus at least one overflow bit above OUTW.
  function automatic bit widths_ok(input int inw, input int outw);
    return inw >= outw + 2;
  endfunction

endpackage

// File: rtl/clamp_seq_if.sv
// rtl/clamp_seq_if.sv - input/output stream bundle for clamp_seq
// Purpose: groups the input vector handshake and the clamped result handshake.
// Ports:   in_valid/in_ready/in_data  - packed signed input vector stream
//          out_valid/out_ready/out_data/out_sat - packed unsigned result stream
//          master modport: stimulus/sink side; slave modport: clamp_seq side.
interface clamp_seq_if #(
  parameter int INW   = 16,
  parameter int OUTW  = 8,
  parameter int NCOMP = 3
);

  logic                    in_valid;
  logic                    in_ready;
  logic [NCOMP*INW-1:0]    in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [NCOMP*OUTW-1:0]   out_data;
  logic [NCOMP-1:0]        out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/clamp_seq_clamp.sv
// rtl/clamp_seq_clamp.sv - combinational signed-to-unsigned positive clamp
// Purpose: maps a signed INW-bit value onto 0..2^OUTW-1.
// Ports:   value  - signed input component
//          result - clamped unsigned component
module clamp_seq_clamp #(
  parameter int INW  = 16,
  parameter int OUTW = 8
) (
  input  logic signed [INW-1:0] value,
  output logic [OUTW-1:0]       result
);

  always_comb begin
    result = value[OUTW-1:0];
    if (value[INW-1]) begin
      result = '0;
    end else if (|value[INW-2:OUTW]) begin
      result = '1;
    end
  end

endmodule

// File: rtl/clamp_seq.sv
// rtl/clamp_seq.sv - time-multiplexed clamp of a packed signed vector
// Purpose: accepts one packed signed vector, clamps one component per cycle
//          through a single shared clamp stage, then holds the packed unsigned
//          result and per-component saturation flags until the sink takes it.
// Ports:   clk, rst   - clock and synchronous active-high reset
//          bus        - clamp_seq_if slave: input vector and result streams
//          sat_clear  - synchronous clear of sat_count (wins over increment)
//          sat_count  - saturating count of clamped components
//          busy       - high whenever the sequencer is not idle
module clamp_seq
  import clamp_seq_pkg::*;
#(
  parameter int INW   = 16,
  parameter int OUTW  = 8,
  parameter int NCOMP = 3,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  clamp_seq_if.slave      bus,
  input  logic            sat_clear,
  output logic [CNTW-1:0] sat_count,
  output logic            busy
);

  localparam int             IW   = idx_width(NCOMP);
  localparam logic [IW-1:0]  LAST = IW'(NCOMP - 1);

  if (!widths_ok(INW, OUTW)) begin : g_width_check
    $error("clamp_seq: INW must be at least OUTW+2");
  end

  state_t                  state, state_n;
  logic [NCOMP*INW-1:0]    src_reg;
  logic [IW-1:0]           idx;
  logic [NCOMP*OUTW-1:0]   res_reg;
  logic [NCOMP-1:0]        flag_reg;
  logic                    accept;
  logic                    run;

  logic signed [INW-1:0]   cur;
  logic [OUTW-1:0]         cur_clamped;
  logic                    cur_flag;

  // Single shared clamp, fed by the component selected by idx.
  assign cur      = src_reg[idx*INW +: INW];
  assign cur_flag = cur[INW-1] | (|cur[INW-2:OUTW]);

  clamp_seq_clamp #(
    .INW  (INW),
    .OUTW (OUTW)
  ) u_clamp (
    .value  (cur),
    .result (cur_clamped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    accept       = 1'b0;
    run          = 1'b0;
    bus.in_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        run = 1'b1;
        if (idx == LAST) begin
          state_n = HOLD;
        end
      end
      HOLD: begin
        // A new vector may enter on the same edge the held result leaves.
        bus.in_ready = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            accept  = 1'b1;
            state_n = RUN;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (rst) begin
      bus.in_ready = 1'b0;
      accept       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_reg  <= '0;
      idx      <= '0;
      res_reg  <= '0;
      flag_reg <= '0;
    end else if (accept) begin
      src_reg <= bus.in_data;
      idx     <= '0;
    end else if (run) begin
      res_reg[idx*OUTW +: OUTW] <= cur_clamped;
      flag_reg[idx]             <= cur_flag;
      idx                       <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  // A clamp event landing on a sat_clear cycle is dropped, not carried over.
  always_ff @(posedge clk) begin
    if (rst || sat_clear) begin
      sat_count <= '0;
    end else if (run && cur_flag && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = res_reg;
  assign bus.out_sat   = flag_reg;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_clamp_seq.sv
// tb/tb_clamp_seq.sv - scoreboard testbench for clamp_seq
module tb_clamp_seq;

  localparam int INW   = 16;
  localparam int OUTW  = 8;
  localparam int NCOMP = 3;
  localparam int CNTW  = 10;
  localparam int VMAX  = (1 << OUTW) - 1;
  localparam int CMAX  = (1 << CNTW) - 1;

  typedef struct {
    logic [NCOMP*OUTW-1:0] data;
    logic [NCOMP-1:0]      sat;
    int                    acc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            sat_clear;
  logic [CNTW-1:0] sat_count;
  logic            busy;

  clamp_seq_if #(.INW(INW), .OUTW(OUTW), .NCOMP(NCOMP)) bus ();

  clamp_seq #(
    .INW   (INW),
    .OUTW  (OUTW),
    .NCOMP (NCOMP),
    .CNTW  (CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .sat_clear (sat_clear),
    .sat_count (sat_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];
  logic prev_valid = 1'b0;

  int   acc_cnt = 0;
  int   next_comp[NCOMP];
  int   m_seen = 0;
  int   m_comp[NCOMP];
  int   m_cnt = 0;
  int   m_k = 0;
  bit   m_run = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [NCOMP*INW-1:0] pack(input int c2, input int c1, input int c0);
    logic [NCOMP*INW-1:0] v;
    int c[NCOMP];
    c[0] = c0;
    c[1] = c1;
    c[2] = c2;
    for (int k = 0; k < NCOMP; k++) v[k*INW +: INW] = c[k][INW-1:0];
    return v;
  endfunction

  function automatic int comp_of(input logic [NCOMP*INW-1:0] v, input int k);
    logic signed [INW-1:0] c;
    c = v[k*INW +: INW];
    return int'(c);
  endfunction

  function automatic bit is_sat(input int x);
    return (x < 0) || (x > VMAX);
  endfunction

  function automatic exp_t expect_vec(input logic [NCOMP*INW-1:0] v);
    exp_t e;
    int   x;
    e.acc = 0;
    for (int k = 0; k < NCOMP; k++) begin
      x = comp_of(v, k);
      e.sat[k] = is_sat(x);
      if (x < 0)         e.data[k*OUTW +: OUTW] = '0;
      else if (x > VMAX) e.data[k*OUTW +: OUTW] = '1;
      else               e.data[k*OUTW +: OUTW] = x[OUTW-1:0];
    end
    return e;
  endfunction

  // Reference saturation counter, stepped on each rising edge.
  always @(posedge clk) begin
    bit ev;
    cyc++;
    if (rst) begin
      m_cnt = 0;
      m_run = 1'b0;
      m_seen = acc_cnt;
    end else begin
      ev = m_run && is_sat(m_comp[m_k]);
      if (sat_clear)                m_cnt = 0;
      else if (ev && m_cnt < CMAX)  m_cnt++;
      if (m_run) begin
        m_k++;
        if (m_k == NCOMP) m_run = 1'b0;
      end
      if (acc_cnt != m_seen) begin
        m_seen = acc_cnt;
        m_comp = next_comp;
        m_run  = 1'b1;
        m_k    = 0;
      end
    end
  end

  // Scoreboard: push on accept, check latency on rise, pop on result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) begin
        if (sb.size() == 0) check("unexpected_valid", 1, 0);
        else                check("latency", 64'(cyc - sb[0].acc), NCOMP);
      end
      if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("out_data", bus.out_data, e.data);
        check("out_sat", bus.out_sat, e.sat);
      end
      if (bus.in_valid && bus.in_ready) begin
        e = expect_vec(bus.in_data);
        e.acc = cyc + 1;
        sb.push_back(e);
        for (int k = 0; k < NCOMP; k++) next_comp[k] = comp_of(bus.in_data, k);
        acc_cnt++;
      end
      prev_valid = bus.out_valid;
    end
  end

  task automatic send(input logic [NCOMP*INW-1:0] v);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = bus.in_ready;
      n++;
    end
    if (!ok) begin
      check("send_timeout", 0, 1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 0, 1);
  endtask

  initial begin
    exp_t ea;
    int   n;
    rst           = 1'b1;
    sat_clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_out_valid", bus.out_valid, 0);
    check("idle_sat_count", sat_count, 0);
    check("idle_busy", busy, 0);
    check("idle_out_data", bus.out_data, 0);
    check("idle_out_sat", bus.out_sat, 0);

    // Single vector with free-running sink.
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(pack(300, -5, 128));
    wait_drain();
    check("single_sat_count", sat_count, 2);

    // Backpressure with a second vector waiting.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    ea = expect_vec(pack(10, -20, 400));
    send(pack(10, -20, 400));
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;
    bus.in_data  = pack(-7, 77, 1000);
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_data", bus.out_data, ea.data);
      check("bp_hold_sat", bus.out_sat, ea.sat);
      check("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(pack(-7, 77, 1000));
    wait_drain();

    // Boundary values.
    send(pack(255, 256, -1));
    send(pack(-32768, 32767, 0));
    send(pack(0, 255, -32768));
    wait_drain();
    check("bound_sat_count", sat_count, 64'(m_cnt));

    // Drive the counter past full scale; it must stick at all-ones.
    for (int i = 0; i < 400; i++) send(pack(-1, 256, 32767));
    wait_drain();
    check("cnt_hold_max", sat_count, CMAX);
    check("cnt_model", sat_count, 64'(m_cnt));

    // Clear on a cycle that also carries a clamp event.
    send(pack(1000, 1000, 1000));
    sat_clear = 1'b1;
    @(posedge clk);
    #1 sat_clear = 1'b0;
    @(negedge clk);
    check("clear_zero", sat_count, 64'(m_cnt));
    wait_drain();
    check("clear_after", sat_count, 64'(m_cnt));

    // Reset while idx==1: the vector must vanish.
    send(pack(1, 2, 3));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("rst_mid_no_valid", bus.out_valid, 0);
    end
    check("rst_mid_busy", busy, 0);
    check("rst_mid_sat_count", sat_count, 0);
    send(pack(50, -50, 500));
    wait_drain();
    check("final_sat_count", sat_count, 64'(m_cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
